// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the core data port and a handshaked SRAM write port.
// Stores drain in FIFO order; loads forward from the youngest matching pending store.
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] Data2Mem,
  output logic [DATA_W-1:0] ReadDataMem,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic store_req;
  logic load_req;
  logic full;
  logic push;
  logic pop;

  assign store_req = ~CEN & ~WEN;
  assign load_req  = ~CEN & ~OEN & WEN;
  assign full      = (count == CW'(DEPTH));
  // Stall is judged on the registered count only, so a same-cycle pop never lifts it.
  assign push      = store_req & ~full;
  assign pop       = mem_wr_valid & mem_wr_ready;

  assign stall        = store_req & full;
  assign empty        = (count == '0);
  assign mem_wr_valid = ~empty;
  assign mem_wr_addr  = mem_wr_valid ? addr_mem[head] : '0;
  assign mem_wr_data  = mem_wr_valid ? data_mem[head] : '0;
  assign mem_raddr    = A;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= A;
      data_mem[tail] <= Data2Mem;
    end
  end

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PW-1:0]     idx;

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (addr_mem[idx] == A)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[idx];
      end
    end
  end

  always_comb begin
    ReadDataMem = '0;
    if (load_req) ReadDataMem = fwd_hit ? fwd_data : mem_rdata;
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized and directed bench for dmem_store_buffer against a queue-based model
// of the buffer plus a behavioural SRAM that supplies mem_rdata.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CEN, WEN, OEN;
  logic [6:0]  A;
  logic [31:0] Data2Mem;
  logic [31:0] ReadDataMem;
  logic        stall;
  logic [6:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_wr_valid;
  logic [6:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ready;
  logic        empty;

  logic [31:0] sram [128];
  assign mem_rdata = sram[mem_raddr];

  typedef struct packed {
    logic [6:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t       q[$];
  logic [6:0] dlog[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A),
    .Data2Mem(Data2Mem), .ReadDataMem(ReadDataMem), .stall(stall),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wr_valid(mem_wr_valid),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .empty(empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs derived from the pending-store queue and the SRAM contents.
  task automatic check_outputs();
    logic        st, ld, found;
    logic [31:0] exp_rd;
    st = !CEN && !WEN;
    ld = !CEN && !OEN && WEN;
    exp_rd = 32'h0;
    if (ld) begin
      found = 1'b0;
      for (int i = q.size() - 1; i >= 0 && !found; i--)
        if (q[i].a == A) begin exp_rd = q[i].d; found = 1'b1; end
      if (!found) exp_rd = sram[A];
    end
    chk("stall", {31'b0, stall}, {31'b0, st && (q.size() == DEPTH)});
    chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
    chk("wr_valid", {31'b0, mem_wr_valid}, {31'b0, q.size() != 0});
    chk("wr_addr", {25'b0, mem_wr_addr}, (q.size() != 0) ? {25'b0, q[0].a} : 32'h0);
    chk("wr_data", mem_wr_data, (q.size() != 0) ? q[0].d : 32'h0);
    chk("raddr", {25'b0, mem_raddr}, {25'b0, A});
    chk("rdata", ReadDataMem, exp_rd);
  endtask

  // One core cycle: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input logic cen, input logic wen, input logic oen,
                       input logic [6:0] a, input logic [31:0] d, input logic rdy,
                       output logic acc);
    logic push, pop;
    ent_t e;
    @(negedge clk);
    CEN = cen; WEN = wen; OEN = oen; A = a; Data2Mem = d; mem_wr_ready = rdy;
    #1;
    check_outputs();
    push = !cen && !wen && (q.size() < DEPTH);
    pop  = (q.size() != 0) && rdy;
    if (mem_wr_valid && rdy) dlog.push_back(mem_wr_addr);
    acc = push;
    @(posedge clk);
    if (pop) begin
      e = q.pop_front();
      sram[e.a] = e.d;
    end
    if (push) q.push_back('{a: a, d: d});
    #1;
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    cycle(1'b1, 1'b1, 1'b1, 7'd0, 32'h0, rdy, acc);
  endtask

  initial begin
    logic acc;
    int   tries;
    for (int i = 0; i < 128; i++) sram[i] = 32'hA000_0000 | i;
    CEN = 1; WEN = 1; OEN = 1; A = 0; Data2Mem = 0; mem_wr_ready = 0;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", {31'b0, empty}, 32'h1);
    chk("rst_valid", {31'b0, mem_wr_valid}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_rdata", ReadDataMem, 32'h0);
    @(negedge clk); rst_n = 0;

    // Single store drains the next cycle.
    cycle(1'b0, 1'b0, 1'b1, 7'd5, 32'hDEADBEEF, 1'b1, acc);
    chk("single_valid", {31'b0, mem_wr_valid}, 32'h1);
    chk("single_addr", {25'b0, mem_wr_addr}, 32'd5);
    chk("single_data", mem_wr_data, 32'hDEADBEEF);
    idle(1'b1);
    chk("single_empty", {31'b0, empty}, 32'h1);
    cycle(1'b0, 1'b1, 1'b0, 7'd5, 32'h0, 1'b1, acc);
    chk("single_sram", ReadDataMem, 32'hDEADBEEF);

    // Youngest-match forwarding with the SRAM port blocked.
    cycle(1'b0, 1'b0, 1'b1, 7'd9, 32'h11, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b1, 7'd9, 32'h22, 1'b0, acc);
    cycle(1'b0, 1'b1, 1'b0, 7'd9, 32'h0, 1'b0, acc);
    chk("fwd_young", ReadDataMem, 32'h22);
    cycle(1'b0, 1'b1, 1'b0, 7'd3, 32'h0, 1'b0, acc);
    chk("fwd_miss", ReadDataMem, 32'hA000_0003);
    repeat (3) idle(1'b1);

    // Full buffer: stall held until a pop frees a slot, then accepted.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 7'(20 + i), 32'h100 + i, 1'b0, acc);
    cycle(1'b0, 1'b0, 1'b1, 7'd1, 32'h55, 1'b0, acc);
    chk("full_stall", {31'b0, stall}, 32'h1);
    cycle(1'b0, 1'b0, 1'b1, 7'd1, 32'h55, 1'b1, acc);
    chk("full_after_pop", {31'b0, stall}, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 7'd1, 32'h55, 1'b0, acc);
    chk("full_accepted", {31'b0, acc}, 32'h1);
    repeat (6) idle(1'b1);
    cycle(1'b0, 1'b1, 1'b0, 7'd1, 32'h0, 1'b0, acc);
    chk("full_sram", ReadDataMem, 32'h55);

    // Ordering across pointer wrap with ready toggling each cycle.
    dlog.delete();
    for (int i = 0; i < 10; i++) begin
      tries = 0;
      do begin
        cycle(1'b0, 1'b0, 1'b1, 7'(i), $urandom, 1'(tries + i) ^ 1'b1, acc);
        tries++;
      end while (!acc && tries < 20);
      if (!acc) chk("wrap_accept_timeout", 32'h0, 32'h1);
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'(i));
    chk("wrap_empty", {31'b0, empty}, 32'h1);
    chk("wrap_count", dlog.size(), 32'd10);
    for (int i = 0; i < dlog.size() && i < 10; i++) chk("wrap_order", {25'b0, dlog[i]}, i);

    // Store takes priority over load; disabled access returns zero.
    cycle(1'b0, 1'b0, 1'b0, 7'd40, 32'h77, 1'b0, acc);
    chk("prio_rdata", ReadDataMem, 32'h0);
    chk("prio_push", {31'b0, empty}, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 7'd41, 32'h78, 1'b0, acc);
    chk("cen_rdata", ReadDataMem, 32'h0);
    repeat (3) idle(1'b1);

    // Asynchronous reset mid-run discards pending stores.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 7'(60 + i), 32'hBAD0 + i, 1'b0, acc);
    @(negedge clk);
    CEN = 1; WEN = 1; OEN = 1; mem_wr_ready = 1;
    #2 rst_n = 1;
    #1;
    chk("arst_empty", {31'b0, empty}, 32'h1);
    chk("arst_valid", {31'b0, mem_wr_valid}, 32'h0);
    chk("arst_stall", {31'b0, stall}, 32'h0);
    q.delete();
    @(negedge clk); rst_n = 0;
    repeat (3) idle(1'b1);
    cycle(1'b0, 1'b1, 1'b0, 7'd60, 32'h0, 1'b1, acc);
    chk("arst_no_write", ReadDataMem, 32'hA000_003C);

    // Random traffic on a small address range to provoke hits and stalls.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      cycle(op[0], op[1], op[2], 7'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), acc);
    end
    for (int i = 0; i < 10; i++) idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Sits between the single-cycle core's data-memory port (CEN/WEN/OEN/A/Data2Mem/ReadDataMem) and a slower backing data SRAM whose write port has a valid/ready handshake.
- Stores are posted into an in-order FIFO and drained to the SRAM in the background.
- Loads are answered in the same cycle, forwarding from the youngest matching buffered store, otherwise from the SRAM's combinational read port.
- Asserts stall to the core when the buffer cannot accept a store.

Parameters:
DEPTH, 4, store-buffer entries; power of 2, >= 2
ADDR_W, 7, word-address width (matches core output A)
DATA_W, 32, data width

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active-high (asserted when 1; name kept per codebase)
CEN  input  1  core chip enable, active-low
WEN  input  1  core write enable, active-low
OEN  input  1  core output enable, active-low
A  input  ADDR_W  core word address
Data2Mem  input  DATA_W  core store data
ReadDataMem  output  DATA_W  load data to core, combinational
stall  output  1  store refused this cycle; core must hold PC and retry
mem_raddr  output  ADDR_W  SRAM read address, equals A
mem_rdata  input  DATA_W  SRAM combinational read data
mem_wr_valid  output  1  head entry presented to SRAM
mem_wr_addr  output  ADDR_W  head entry address
mem_wr_data  output  DATA_W  head entry data
mem_wr_ready  input  1  SRAM accepts write this cycle
empty  output  1  count == 0 (used before halt and for test checking)

Behaviour:
- State: DEPTH entries {addr, data}, head pointer, tail pointer, count (0..DEPTH). Pointers wrap modulo DEPTH.
- Reset (async, rst_n=1):
  - count=0, head=tail=0.
  - Outputs: mem_wr_valid=0, empty=1, stall=0, ReadDataMem=0. mem_wr_addr and mem_wr_data are 0 when mem_wr_valid=0.
  - Reset mid-drain discards all pending entries; no SRAM write is issued after reset.
- Request decode (combinational):
  - store_req = ~CEN & ~WEN.
  - load_req = ~CEN & ~OEN & WEN. Store wins when both WEN and OEN are low.
- Push:
  - A store is accepted when store_req and count < DEPTH.
  - It writes {A, Data2Mem} at tail, and tail increments at the edge.
  - No coalescing: repeated stores to one address occupy separate entries.
- stall = store_req & (count == DEPTH).
  - A pop in the same cycle does not lift the stall; the store is accepted the next cycle.
  - Loads never stall.
- Drain:
  - mem_wr_valid = (count != 0), presenting the head entry.
  - On mem_wr_valid & mem_wr_ready, head increments at the edge.
  - Strict FIFO order.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (possible only when count < DEPTH).
- Load forwarding:
  - When load_req, compare A against all valid entries.
  - ReadDataMem = data of the youngest matching entry (closest to tail), else mem_rdata.
  - An entry popping this cycle still forwards.
  - When not load_req, ReadDataMem = 0.
- Same-cycle store then load to one address is impossible: a single-cycle core issues one access per cycle. A load in cycle N+1 sees the store from cycle N via forwarding or SRAM.
- mem_raddr = A always. The block never reads the SRAM for its own purposes.
- Latency:
  - Load: 0 cycles, combinational.
  - Store: visible to forwarding from the cycle after acceptance.
  - SRAM write: at least 1 cycle after acceptance.
- Invariants: count <= DEPTH; empty == (count == 0); (tail - head) mod DEPTH == count mod DEPTH.

Test Plan:
- Reset: rst_n=1 mid-run with count=3 -> empty=1, mem_wr_valid=0, stall=0 immediately (async). After release, no SRAM write occurs.
- Single store drain: store A=5, D=0xDEADBEEF with mem_wr_ready=1 -> next cycle mem_wr_valid=1, addr 5, data 0xDEADBEEF. Following cycle empty=1; SRAM[5]=0xDEADBEEF.
- Forwarding youngest: mem_wr_ready=0; store A=9 D=0x11, then A=9 D=0x22; load A=9 -> ReadDataMem=0x22. Load A=3 -> ReadDataMem=mem_rdata.
- Full/stall: mem_wr_ready=0; 4 stores accepted. 5th store (A=1 D=0x55) -> stall=1 while held. Raise mem_wr_ready for 1 cycle -> store accepted the next cycle, stall=0, count=4.
- Ordering/wrap: 10 stores to A=0..9 with mem_wr_ready toggling 1/0 each cycle -> SRAM receives writes in order 0..9. Pointers wrap twice; final empty=1.
- Priority/idle: CEN=0, WEN=0, OEN=0 -> treated as store, ReadDataMem=0. CEN=1 -> no push, ReadDataMem=0.
